// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - trap/eret sequencer: drain bus, flush pipeline, redirect PC
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        exc_req,
    input  logic        eret_m,
    input  logic [31:0] epc,
    input  logic        bus_busy,
    output logic        pipe_hold,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exl_clr,
    output logic [15:0] entry_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    typedef enum logic {
        K_TRAP,
        K_ERET
    } kind_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] entry_cnt_q, entry_cnt_d;
    logic        trap;

    assign trap      = int_req | exc_req;
    assign entry_cnt = entry_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= K_TRAP;
            tgt_q       <= 32'd0;
            cnt_q       <= 4'd0;
            entry_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            entry_cnt_q <= entry_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        tgt_d          = tgt_q;
        cnt_d          = cnt_q;
        entry_cnt_d    = entry_cnt_q;
        pipe_hold      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        exl_clr        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A trap outranks a coincident eret; the eret is simply dropped.
                if (trap) begin
                    kind_d      = K_TRAP;
                    entry_cnt_d = entry_cnt_q + 16'd1;
                    state_d     = bus_busy ? S_DRAIN : S_FLUSH;
                    cnt_d       = FLUSH_LOAD;
                end else if (eret_m) begin
                    kind_d  = K_ERET;
                    tgt_d   = epc;
                    state_d = bus_busy ? S_DRAIN : S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            S_DRAIN: begin
                pipe_hold = 1'b1;
                if (!bus_busy) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                pipe_hold = 1'b1;
                flush     = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REDIRECT: begin
                pipe_hold      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = (kind_q == K_TRAP) ? HANDLER_ADDR : tgt_q;
                exl_clr        = (kind_q == K_ERET);
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - self-checking bench for exc_sequencer
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        int_req = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret_m = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        bus_busy = 1'b0;
    logic        pipe_hold;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exl_clr;
    logic [15:0] entry_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [32:0] sb[$];
    logic [32:0] exp_rd;

    localparam logic [31:0] HANDLER = 32'h0000_4180;

    exc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .exc_req        (exc_req),
        .eret_m         (eret_m),
        .epc            (epc),
        .bus_busy       (bus_busy),
        .pipe_hold      (pipe_hold),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exl_clr        (exl_clr),
        .entry_cnt      (entry_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer and per-cycle invariants.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (flush && redirect_valid) begin
                n_fail++;
                $display("FAIL overlap: flush=%0b redirect_valid=%0b, required not both", flush, redirect_valid);
            end
            n_checks++;
            if (exl_clr && !redirect_valid) begin
                n_fail++;
                $display("FAIL exl_alone: exl_clr=1 with redirect_valid=0");
            end
            if (redirect_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_redirect: pc=%h exl_clr=%0b, none expected", redirect_pc, exl_clr);
                end else begin
                    exp_rd = sb.pop_front();
                    if ({exl_clr, redirect_pc} !== exp_rd) begin
                        n_fail++;
                        $display("FAIL redirect: got exl_clr=%0b pc=%h, required exl_clr=%0b pc=%h",
                                 exl_clr, redirect_pc, exp_rd[32], exp_rd[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int_req  = ~int_req;
            exc_req  = ~exc_req;
            eret_m   = ~eret_m;
            bus_busy = ~bus_busy;
            epc      = $urandom;
            tick();
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid, redirect_pc, exl_clr, entry_cnt} !== 52'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: hold=%0b flush=%0b rv=%0b pc=%h exl=%0b cnt=%h, required all 0",
                         pipe_hold, flush, redirect_valid, redirect_pc, exl_clr, entry_cnt);
            end
        end
        int_req = 1'b0; exc_req = 1'b0; eret_m = 1'b0; bus_busy = 1'b0;
        tick();
        reset = 1'b0;
        exp_cnt = 16'd0;
        tick();
    endtask

    task automatic test_interrupt();
        int_req = 1'b1;
        sb.push_back({1'b0, HANDLER});
        exp_cnt++;
        tick();
        int_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid} !== {i < 3, i < 2, i == 2}) begin
                n_fail++;
                $display("FAIL int_seq[%0d]: hold/flush/rv=%b, required %b", i,
                         {pipe_hold, flush, redirect_valid}, {i < 3, i < 2, i == 2});
            end
            tick();
        end
        n_checks++;
        if (entry_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL int_cnt: entry_cnt=%h, required %h", entry_cnt, exp_cnt);
        end
    endtask

    task automatic test_eret();
        eret_m = 1'b1;
        epc    = 32'h0000_3010;
        sb.push_back({1'b1, 32'h0000_3010});
        tick();
        eret_m = 1'b0;
        epc    = 32'h0000_5000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid} !== {i < 3, i < 2, i == 2}) begin
                n_fail++;
                $display("FAIL eret_seq[%0d]: hold/flush/rv=%b, required %b", i,
                         {pipe_hold, flush, redirect_valid}, {i < 3, i < 2, i == 2});
            end
            tick();
        end
        n_checks++;
        if (entry_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL eret_cnt: entry_cnt=%h, required %h", entry_cnt, exp_cnt);
        end
    endtask

    task automatic test_drain();
        bus_busy = 1'b1;
        exc_req  = 1'b1;
        sb.push_back({1'b0, HANDLER});
        exp_cnt++;
        tick();
        exc_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid} !== {i < 6, i == 3 || i == 4, i == 5}) begin
                n_fail++;
                $display("FAIL drain_seq[%0d]: hold/flush/rv=%b, required %b", i,
                         {pipe_hold, flush, redirect_valid}, {i < 6, i == 3 || i == 4, i == 5});
            end
            if (i == 2) bus_busy = 1'b0;
            tick();
        end
        n_checks++;
        if (pipe_hold !== 1'b0 || entry_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL drain_end: hold=%0b cnt=%h, required hold=0 cnt=%h", pipe_hold, entry_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int_req = 1'b1;
        eret_m  = 1'b1;
        epc     = 32'h0000_7777;
        sb.push_back({1'b0, HANDLER});
        exp_cnt++;
        tick();
        int_req = 1'b0;
        eret_m  = 1'b0;
        exc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid} !== {i < 3, i < 2, i == 2}) begin
                n_fail++;
                $display("FAIL simul_seq[%0d]: hold/flush/rv=%b, required %b", i,
                         {pipe_hold, flush, redirect_valid}, {i < 3, i < 2, i == 2});
            end
            if (i == 1) exc_req = 1'b0;
            tick();
        end
        n_checks++;
        if (entry_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL simul_cnt: entry_cnt=%h, required %h", entry_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.entry_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.entry_cnt_q;
        exp_cnt = 16'hFFFF;
        tick();
        n_checks++;
        if (entry_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_preload: entry_cnt=%h, required %h", entry_cnt, exp_cnt);
        end
        exc_req = 1'b1;
        sb.push_back({1'b0, HANDLER});
        exp_cnt++;
        tick();
        exc_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (entry_cnt !== exp_cnt || exp_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: entry_cnt=%h, required 0000", entry_cnt);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_flush();
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_flush: flush=%0b, required 1", flush);
        end
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pipe_hold, flush, redirect_valid, entry_cnt} !== 19'd0) begin
                n_fail++;
                $display("FAIL rst_abort[%0d]: hold=%0b flush=%0b rv=%0b cnt=%h, required all 0",
                         i, pipe_hold, flush, redirect_valid, entry_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_eret();
        test_drain();
        test_back_to_back();
        test_wrap();
        test_reset_flush();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d redirects outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
